// File: rtl/ev21g1_io_bank.sv
// Parameterised I/O bank: synchronised input ports with sticky change flags and
// an interrupt, plus read-modify-write output registers.
module ev21g1_io_bank #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_PORTS   = 2,
  parameter int SYNC_STAGES = 2,
  localparam int SW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [SW-1:0]                   wr_sel,
  input  logic [1:0]                      wr_op,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic                            rd_en,
  input  logic [SW-1:0]                   rd_sel,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic                            rd_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_ports,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] out_ports,
  output logic [NUM_PORTS-1:0]            chg_flags,
  output logic                            irq
);

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } wr_op_t;

  localparam logic [SW:0] PORT_LIMIT = (SW+1)'(NUM_PORTS);

  logic [DATA_WIDTH-1:0] sync_q [NUM_PORTS][SYNC_STAGES];
  logic [DATA_WIDTH-1:0] cap_q  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] out_q  [NUM_PORTS];
  logic [NUM_PORTS-1:0]  chg_q;
  logic [NUM_PORTS-1:0]  chg_set;
  logic [NUM_PORTS-1:0]  chg_clr;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  irq_q;
  logic                  rd_hit;
  logic                  wr_hit;

  assign rd_hit = rd_en && ({1'b0, rd_sel} < PORT_LIMIT);
  assign wr_hit = wr_en && ({1'b0, wr_sel} < PORT_LIMIT);

  function automatic logic [DATA_WIDTH-1:0] apply_op(
    input logic [1:0]            op,
    input logic [DATA_WIDTH-1:0] cur,
    input logic [DATA_WIDTH-1:0] opd
  );
    case (wr_op_t'(op))
      OP_LOAD:  return opd;
      OP_SET:   return cur | opd;
      OP_CLEAR: return cur & ~opd;
      default:  return cur ^ opd;
    endcase
  endfunction

  // Input synchronisers and the captured register that trails the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        cap_q[k] <= '0;
        for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
          sync_q[k][s] <= '0;
        end
      end
    end else begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        sync_q[k][0] <= in_ports[k*DATA_WIDTH +: DATA_WIDTH];
        for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
          sync_q[k][s] <= sync_q[k][s-1];
        end
        cap_q[k] <= sync_q[k][SYNC_STAGES-1];
      end
    end
  end

  always_comb begin
    chg_set = '0;
    chg_clr = '0;
    rd_mux  = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      chg_set[k] = (sync_q[k][SYNC_STAGES-1] != cap_q[k]);
      chg_clr[k] = rd_hit && (rd_sel == SW'(k));
      if (rd_sel == SW'(k)) begin
        rd_mux = cap_q[k];
      end
    end
  end

  // A new change in the same cycle as a read-clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_q <= '0;
      irq_q <= 1'b0;
    end else begin
      chg_q <= chg_set | (chg_q & ~chg_clr);
      irq_q <= |chg_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= rd_hit ? rd_mux : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        out_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        if (wr_hit && (wr_sel == SW'(k))) begin
          out_q[k] <= apply_op(wr_op, out_q[k], wr_data);
        end
      end
    end
  end

  always_comb begin
    out_ports = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      out_ports[k*DATA_WIDTH +: DATA_WIDTH] = out_q[k];
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign chg_flags = chg_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_ev21g1_io_bank.sv
// Directed-vector bench for ev21g1_io_bank: a default two-port instance and a
// three-port instance for out-of-range select handling.
module tb_ev21g1_io_bank;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance (2 ports, SW = 1)
  logic        wr_en, rd_en;
  logic [0:0]  wr_sel, rd_sel;
  logic [1:0]  wr_op;
  logic [31:0] wr_data, rd_data;
  logic        rd_valid, irq;
  logic [63:0] in_ports, out_ports;
  logic [1:0]  chg_flags;

  // Three-port instance (SW = 2)
  logic        wr_en3, rd_en3;
  logic [1:0]  wr_sel3, rd_sel3;
  logic [1:0]  wr_op3;
  logic [31:0] wr_data3, rd_data3;
  logic        rd_valid3, irq3;
  logic [95:0] in_ports3, out_ports3;
  logic [2:0]  chg_flags3;

  ev21g1_io_bank dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_op(wr_op), .wr_data(wr_data),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid),
    .in_ports(in_ports), .out_ports(out_ports), .chg_flags(chg_flags), .irq(irq)
  );

  ev21g1_io_bank #(.NUM_PORTS(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en3), .wr_sel(wr_sel3), .wr_op(wr_op3), .wr_data(wr_data3),
    .rd_en(rd_en3), .rd_sel(rd_sel3), .rd_data(rd_data3), .rd_valid(rd_valid3),
    .in_ports(in_ports3), .out_ports(out_ports3), .chg_flags(chg_flags3), .irq(irq3)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one active edge and settle on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    wr_en = 0; wr_sel = '0; wr_op = 2'b00; wr_data = '0;
    rd_en = 0; rd_sel = '0; in_ports = '0;
    wr_en3 = 0; wr_sel3 = '0; wr_op3 = 2'b00; wr_data3 = '0;
    rd_en3 = 0; rd_sel3 = '0; in_ports3 = '0;
    #3;
    check("rst_out", out_ports, 0);
    check("rst_rd", {rd_valid, rd_data}, 0);
    check("rst_flags", {irq, chg_flags}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Loads to both ports
    wr_en = 1; wr_sel = 0; wr_op = 2'b00; wr_data = 32'h0000_03C0;
    step();
    check("load_p0", out_ports, 64'h0000_0000_0000_03C0);
    wr_sel = 1; wr_data = 32'h0000_01C0;
    step();
    check("load_p1", out_ports, 64'h0000_01C0_0000_03C0);

    // Back-to-back read-modify-write on port 0
    wr_sel = 0; wr_op = 2'b00; wr_data = 32'h0000_FF00;
    step();
    check("rmw_load", out_ports[31:0], 32'h0000_FF00);
    wr_op = 2'b01; wr_data = 32'h0000_00FF;
    step();
    check("rmw_set", out_ports[31:0], 32'h0000_FFFF);
    wr_op = 2'b10; wr_data = 32'h0000_F000;
    step();
    check("rmw_clear", out_ports[31:0], 32'h0000_0FFF);
    wr_op = 2'b11; wr_data = 32'hFFFF_FFFF;
    step();
    check("rmw_toggle", out_ports, 64'h0000_01C0_FFFF_F000);
    wr_en = 0;

    // Input change on port 1: flag after 3 edges, irq after 4
    in_ports[63:32] = 32'hDEAD_BEEF;
    step();
    check("chg_e1", chg_flags, 2'b00);
    step();
    check("chg_e2", chg_flags, 2'b00);
    step();
    check("chg_e3", {irq, chg_flags}, 3'b010);
    step();
    check("irq_e4", {irq, chg_flags}, 3'b110);
    rd_en = 1; rd_sel = 1;
    step();
    check("rd_p1", {rd_valid, rd_data}, {1'b1, 32'hDEAD_BEEF});
    check("rd_clr", chg_flags, 2'b00);
    rd_en = 0;
    step();
    check("rd_hold", {rd_valid, rd_data}, {1'b0, 32'hDEAD_BEEF});
    check("irq_clr", irq, 1'b0);

    // Set beats a read-clear landing in the same cycle
    in_ports[63:32] = 32'hA5A5_A5A5;
    step(); step(); step();
    check("chg_a5", chg_flags, 2'b10);
    in_ports[63:32] = 32'h5A5A_5A5A;
    step(); step();
    rd_en = 1; rd_sel = 1;
    step();
    check("setwin_rd", {rd_valid, rd_data}, {1'b1, 32'hA5A5_A5A5});
    check("setwin_flag", chg_flags, 2'b10);
    rd_en = 0;
    step();
    check("setwin_hold", chg_flags, 2'b10);
    rd_en = 1;
    step();
    check("rd_5a", {rd_valid, rd_data, chg_flags}, {1'b1, 32'h5A5A_5A5A, 2'b00});
    rd_en = 0;

    // Three-port instance: out-of-range selects
    wr_en3 = 1; wr_sel3 = 2; wr_op3 = 2'b00; wr_data3 = 32'hAAAA_0000;
    step();
    check("p3_load", out_ports3, {32'hAAAA_0000, 64'h0});
    wr_sel3 = 3; wr_data3 = 32'hFFFF_FFFF;
    step();
    check("p3_wr_oob", out_ports3, {32'hAAAA_0000, 64'h0});
    wr_en3 = 0;
    in_ports3[31:0] = 32'h0000_0011;
    step(); step(); step();
    check("p3_chg0", chg_flags3, 3'b001);
    rd_en3 = 1; rd_sel3 = 0;
    step();
    check("p3_rd0", {rd_valid3, rd_data3, chg_flags3}, {1'b1, 32'h0000_0011, 3'b000});
    rd_en3 = 0;
    in_ports3[63:32] = 32'h0000_0022;
    step(); step(); step();
    check("p3_chg1", chg_flags3, 3'b010);
    rd_en3 = 1; rd_sel3 = 3;
    step();
    check("p3_rd_oob", {rd_valid3, rd_data3, chg_flags3}, {1'b1, 32'h0, 3'b010});
    rd_en3 = 0;

    // Asynchronous reset between edges, with a write and a read pending
    wr_en = 1; wr_sel = 0; wr_op = 2'b00; wr_data = 32'h1234_5678;
    step();
    check("pre_rst", out_ports[31:0], 32'h1234_5678);
    wr_op = 2'b11; wr_data = 32'hFFFF_FFFF; rd_en = 1; rd_sel = 0;
    #2 rst_n = 1'b0;
    #1;
    check("async_out", out_ports, 0);
    check("async_rd", {rd_valid, rd_data, chg_flags, irq}, 0);
    check("async_p3", {out_ports3, chg_flags3, rd_data3}, 0);
    step();
    check("rst_held", {rd_valid, out_ports}, 0);

    // Release with nonzero inputs; first edge performs a write
    rst_n = 1'b1;
    rd_en = 0; wr_sel = 1; wr_op = 2'b00; wr_data = 32'h0000_0077;
    in_ports[31:0] = 32'h0000_0055;
    step();
    check("post_rst_wr", {out_ports, chg_flags}, {64'h0000_0077_0000_0000, 2'b00});
    wr_en = 0;
    step();
    check("post_rst_e2", chg_flags, 2'b00);
    step();
    check("post_rst_e3", {irq, chg_flags, chg_flags3}, {1'b0, 2'b11, 3'b011});
    step();
    check("post_rst_irq", {irq, irq3}, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
